// File: rtl/ikaopll_pg_tdm.sv
// Time-division-multiplexed FM phase generator: one shared PM/block/MUL/accumulate
// pipeline serves SLOTS operator slots, with per-slot freeze and a host phase read port.
module ikaopll_pg_tdm #(
    parameter int unsigned SLOTS   = 18,
    parameter int unsigned FNUM_W  = 9,
    parameter int unsigned BLOCK_W = 3,
    parameter int unsigned PHASE_W = 19,
    parameter int unsigned OUT_W   = 10
) (
    input  logic               i_EMUCLK,
    input  logic               i_RST,
    input  logic               i_phi1_NCEN_n,
    input  logic               i_SYNC,
    input  logic [FNUM_W-1:0]  i_FNUM,
    input  logic [BLOCK_W-1:0] i_BLOCK,
    input  logic [3:0]         i_MUL,
    input  logic               i_PM,
    input  logic [2:0]         i_PMVAL,
    input  logic               i_PHASE_RST,
    input  logic               i_FREEZE,
    input  logic               i_RD_REQ,
    input  logic [4:0]         i_RD_SLOT,
    output logic [OUT_W-1:0]   o_OP_PHASE,
    output logic [4:0]         o_OP_SLOT,
    output logic               o_OP_VALID,
    output logic               o_RD_ACK,
    output logic [PHASE_W-1:0] o_RD_DATA,
    output logic               o_RD_ERR
);

    localparam int unsigned D0_W    = FNUM_W + 2;
    localparam int unsigned DB_W    = D0_W + (1 << BLOCK_W) - 1;
    localparam int unsigned PR_W    = DB_W + 4;
    localparam int unsigned SLOT_AW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {RdIdle, RdWait, RdAck} rd_state_e;

    logic tick;
    assign tick = ~i_phi1_NCEN_n;

    logic [4:0] slot_q;

    logic [FNUM_W-1:0]  s0_fnum;
    logic [BLOCK_W-1:0] s0_block;
    logic [3:0]         s0_mul;
    logic               s0_pm;
    logic [2:0]         s0_pmval;
    logic               s0_prst;
    logic               s0_frz;
    logic [4:0]         s0_slot;

    logic [DB_W-1:0]    s1_db;
    logic [3:0]         s1_mul;
    logic               s1_prst;
    logic               s1_frz;
    logic [4:0]         s1_slot;

    logic [PHASE_W-1:0] s2_delta;
    logic               s2_prst;
    logic [4:0]         s2_slot;

    logic [OUT_W-1:0]   op_phase_q;
    logic [4:0]         op_slot_q;
    logic [1:0]         prime_q;
    logic               op_valid_q;

    logic [PHASE_W-1:0] phase_q [SLOTS];
    logic [PHASE_W-1:0] phase_new;

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            slot_q <= '0;
        end else if (tick) begin
            if (i_SYNC || slot_q == 5'(SLOTS - 1)) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_q + 5'd1;
            end
        end
    end

    // S1: vibrato offset and block shift
    logic               pm_neg;
    logic [1:0]         pm_sel;
    logic [2:0]         pm_amt;
    logic [D0_W-1:0]    pm_ext;
    logic [D0_W-1:0]    d0;
    logic [DB_W-1:0]    db;

    always_comb begin
        pm_neg = s0_pmval[2] & s0_pm;
        pm_sel = s0_pmval[1:0] & {2{s0_pm}};
        pm_amt = 3'd0;
        case (pm_sel)
            2'd1, 2'd3: pm_amt = {1'b0, s0_fnum[FNUM_W-1 -: 2]};
            2'd2:       pm_amt = s0_fnum[FNUM_W-1 -: 3];
            default:    pm_amt = 3'd0;
        endcase
        pm_ext = D0_W'(pm_amt);
        if (pm_neg) begin
            pm_ext = -pm_ext;
        end
        d0 = {1'b0, s0_fnum, 1'b0} + pm_ext;
        // Borrow out of the negative add lands in the MSB; drop it
        if (pm_neg) begin
            d0[D0_W-1] = 1'b0;
        end
        db = (DB_W'(d0) << s0_block) >> 1;
    end

    // S2: multiplier
    logic [3:0]      mul_fac;
    logic [DB_W-1:0] db_in;
    logic [PR_W-1:0] prod;

    always_comb begin
        db_in   = s1_db;
        mul_fac = s1_mul;
        case (s1_mul)
            4'h0: begin
                db_in   = s1_db >> 1;
                mul_fac = 4'd1;
            end
            4'hA, 4'hB: mul_fac = 4'd10;
            4'hC, 4'hD: mul_fac = 4'd12;
            4'hE, 4'hF: mul_fac = 4'd15;
            default:    mul_fac = s1_mul;
        endcase
        prod = PR_W'(db_in) * PR_W'(mul_fac);
    end

    // S3: a slot recurs only every SLOTS ticks, so this read always sees its last write
    assign phase_new = s2_delta + (s2_prst ? '0 : phase_q[SLOT_AW'(s2_slot)]);

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            s0_fnum    <= '0;
            s0_block   <= '0;
            s0_mul     <= '0;
            s0_pm      <= 1'b0;
            s0_pmval   <= '0;
            s0_prst    <= 1'b0;
            s0_frz     <= 1'b0;
            s0_slot    <= '0;
            s1_db      <= '0;
            s1_mul     <= '0;
            s1_prst    <= 1'b0;
            s1_frz     <= 1'b0;
            s1_slot    <= '0;
            s2_delta   <= '0;
            s2_prst    <= 1'b0;
            s2_slot    <= '0;
            op_phase_q <= '0;
            op_slot_q  <= '0;
            prime_q    <= '0;
            op_valid_q <= 1'b0;
        end else if (tick) begin
            s0_fnum    <= i_FNUM;
            s0_block   <= i_BLOCK;
            s0_mul     <= i_MUL;
            s0_pm      <= i_PM;
            s0_pmval   <= i_PMVAL;
            s0_prst    <= i_PHASE_RST;
            s0_frz     <= i_FREEZE;
            s0_slot    <= slot_q;
            s1_db      <= db;
            s1_mul     <= s0_mul;
            s1_prst    <= s0_prst;
            s1_frz     <= s0_frz;
            s1_slot    <= s0_slot;
            s2_delta   <= s1_frz ? '0 : PHASE_W'(prod);
            s2_prst    <= s1_prst;
            s2_slot    <= s1_slot;
            op_phase_q <= phase_new[PHASE_W-1 -: OUT_W];
            op_slot_q  <= s2_slot;
            prime_q    <= {prime_q[0], 1'b1};
            op_valid_q <= prime_q[1];
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                phase_q[SLOT_AW'(i)] <= '0;
            end
        end else if (tick) begin
            phase_q[SLOT_AW'(s2_slot)] <= phase_new;
        end
    end

    // Host read-back FSM
    rd_state_e          rd_state_q, rd_state_d;
    logic [4:0]         rd_slot_q, rd_slot_d;
    logic [PHASE_W-1:0] rd_data_q, rd_data_d;
    logic               rd_err_q, rd_err_d;
    logic               rd_ack_q, rd_ack_d;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_slot_d  = rd_slot_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        rd_ack_d   = (rd_state_q == RdAck);
        case (rd_state_q)
            RdIdle: begin
                if (i_RD_REQ) begin
                    rd_slot_d = i_RD_SLOT;
                    rd_data_d = '0;
                    if ({1'b0, i_RD_SLOT} >= 6'(SLOTS)) begin
                        rd_err_d   = 1'b1;
                        rd_state_d = RdAck;
                    end else begin
                        rd_err_d   = 1'b0;
                        rd_state_d = RdWait;
                    end
                end
            end
            RdWait: begin
                if (s2_slot == rd_slot_q) begin
                    rd_data_d  = phase_new;
                    rd_state_d = RdAck;
                end
            end
            RdAck:   rd_state_d = RdIdle;
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            rd_state_q <= RdIdle;
            rd_slot_q  <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
        end else if (tick) begin
            rd_state_q <= rd_state_d;
            rd_slot_q  <= rd_slot_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            rd_ack_q   <= rd_ack_d;
        end
    end

    assign o_OP_PHASE = op_phase_q;
    assign o_OP_SLOT  = op_slot_q;
    assign o_OP_VALID = op_valid_q;
    assign o_RD_ACK   = rd_ack_q;
    assign o_RD_DATA  = rd_data_q;
    assign o_RD_ERR   = rd_err_q;

endmodule

// File: tb/tb_ikaopll_pg_tdm.sv
// Directed bench for ikaopll_pg_tdm: per-slot stimulus tables with hand-computed deltas and
// a 3-deep expected-write pipe tracking each slot's phase.
module tb_ikaopll_pg_tdm;
    localparam int SLOTS = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ncen, sync, pm, phase_rst, freeze, rd_req;
    logic [8:0]  fnum;
    logic [2:0]  blk, pmval;
    logic [3:0]  mul;
    logic [4:0]  rd_slot;
    logic [9:0]  o_OP_PHASE;
    logic [4:0]  o_OP_SLOT;
    logic        o_OP_VALID, o_RD_ACK, o_RD_ERR;
    logic [18:0] o_RD_DATA;

    ikaopll_pg_tdm dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen), .i_SYNC(sync),
        .i_FNUM(fnum), .i_BLOCK(blk), .i_MUL(mul), .i_PM(pm), .i_PMVAL(pmval),
        .i_PHASE_RST(phase_rst), .i_FREEZE(freeze), .i_RD_REQ(rd_req), .i_RD_SLOT(rd_slot),
        .o_OP_PHASE(o_OP_PHASE), .o_OP_SLOT(o_OP_SLOT), .o_OP_VALID(o_OP_VALID),
        .o_RD_ACK(o_RD_ACK), .o_RD_DATA(o_RD_DATA), .o_RD_ERR(o_RD_ERR)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]  fnum_t  [SLOTS];
    logic [2:0]  blk_t   [SLOTS];
    logic [3:0]  mul_t   [SLOTS];
    logic        pm_t    [SLOTS];
    logic [2:0]  pmval_t [SLOTS];
    logic        frz_t   [SLOTS];
    logic        prst_once [SLOTS];
    logic [18:0] exp_t   [SLOTS];
    logic [18:0] model_phase [SLOTS];

    int          q_slot [3];
    logic [18:0] q_delta [3];
    logic        q_prst [3];
    logic        q_real [3];

    int          cur_slot, since_rst, last_slot;
    logic        sync_req, last_valid, last_real, last_prst;
    logic [18:0] last_delta;

    task automatic clear_tables();
        for (int s = 0; s < SLOTS; s++) begin
            fnum_t[s] = '0; blk_t[s] = '0; mul_t[s] = '0; pm_t[s] = 1'b0;
            pmval_t[s] = '0; frz_t[s] = 1'b0; exp_t[s] = '0;
        end
    endtask

    task automatic init_model();
        for (int s = 0; s < SLOTS; s++) begin
            model_phase[s] = '0;
            prst_once[s] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            q_slot[i] = 0; q_delta[i] = '0; q_prst[i] = 1'b0; q_real[i] = 1'b0;
        end
        cur_slot = 0; since_rst = 0; sync_req = 1'b0;
        last_slot = 0; last_valid = 1'b0; last_real = 1'b0; last_prst = 1'b0; last_delta = '0;
    endtask

    task automatic set_slot(input int s, input logic [8:0] f, input logic [2:0] b,
                            input logic [3:0] m, input logic p, input logic [2:0] pv,
                            input logic [18:0] e);
        fnum_t[s] = f; blk_t[s] = b; mul_t[s] = m; pm_t[s] = p; pmval_t[s] = pv; exp_t[s] = e;
    endtask

    // One active tick: drive the current slot's inputs, then retire the oldest expected write
    task automatic step();
        int          s;
        logic [18:0] d;
        logic        p;
        s = cur_slot;
        fnum = fnum_t[s]; blk = blk_t[s]; mul = mul_t[s]; pm = pm_t[s]; pmval = pmval_t[s];
        freeze = frz_t[s]; phase_rst = prst_once[s]; sync = sync_req; ncen = 1'b0;
        d = frz_t[s] ? 19'd0 : exp_t[s];
        p = prst_once[s];
        @(posedge clk);
        #1;
        last_slot = q_slot[2]; last_real = q_real[2]; last_prst = q_prst[2];
        last_delta = q_delta[2];
        if (q_real[2])
            model_phase[q_slot[2]] = (q_prst[2] ? 19'd0 : model_phase[q_slot[2]]) + q_delta[2];
        last_valid = (since_rst >= 2);
        for (int i = 2; i > 0; i--) begin
            q_slot[i] = q_slot[i-1]; q_delta[i] = q_delta[i-1];
            q_prst[i] = q_prst[i-1]; q_real[i] = q_real[i-1];
        end
        q_slot[0] = s; q_delta[0] = d; q_prst[0] = p; q_real[0] = 1'b1;
        prst_once[s] = 1'b0;
        cur_slot = sync_req ? 0 : (s + 1) % SLOTS;
        sync_req = 1'b0;
        since_rst++;
    endtask

    task automatic idle_cycle();
        ncen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input int s, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 3 * SLOTS && !seen; i++) begin
            step();
            if (last_valid && last_real && last_slot == s) seen = 1'b1;
        end
    endtask

    task automatic do_read(input int s, output logic [18:0] data, output logic err,
                           output int lat, output logic got);
        rd_req = 1'b1; rd_slot = 5'(s);
        got = 1'b0; lat = 0; data = '0; err = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            lat++;
            if (o_RD_ACK === 1'b1) begin
                got = 1'b1; data = o_RD_DATA; err = o_RD_ERR;
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ncen = 1'b1; rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests += 6;
        if (o_OP_PHASE !== 10'd0) begin n_fail++; $display("FAIL reset_op_phase got %0h want 0", o_OP_PHASE); end
        if (o_OP_SLOT !== 5'd0) begin n_fail++; $display("FAIL reset_op_slot got %0d want 0", o_OP_SLOT); end
        if (o_OP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %b want 0", o_OP_VALID); end
        if (o_RD_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack got %b want 0", o_RD_ACK); end
        if (o_RD_DATA !== 19'd0) begin n_fail++; $display("FAIL reset_rd_data got %0h want 0", o_RD_DATA); end
        if (o_RD_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err got %b want 0", o_RD_ERR); end
        rst = 1'b0;
        clear_tables();
        init_model();
        step(); step();
        n_tests++;
        if (o_OP_VALID !== 1'b0) begin n_fail++; $display("FAIL valid_tick2 got %b want 0", o_OP_VALID); end
        step();
        n_tests++;
        if (o_OP_VALID !== 1'b1) begin n_fail++; $display("FAIL valid_tick3 got %b want 1", o_OP_VALID); end
    endtask

    task automatic test_ramp();
        int cnt = 0;
        set_slot(0, 9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 19'd4096);
        sync_req = 1'b1;
        step();
        for (int i = 0; i < 3000 && cnt < 128; i++) begin
            step();
            if (last_valid) begin
                n_tests++;
                if (o_OP_SLOT !== 5'(last_slot)) begin
                    n_fail++; $display("FAIL ramp_slot got %0d want %0d", o_OP_SLOT, last_slot);
                end
            end
            if (last_valid && last_real && last_slot == 0 && last_delta != 0) begin
                cnt++;
                n_tests++;
                if (o_OP_PHASE !== model_phase[0][18:9]) begin
                    n_fail++;
                    $display("FAIL ramp_phase frame %0d got %0h want %0h", cnt, o_OP_PHASE,
                             model_phase[0][18:9]);
                end
                if (cnt == 64) begin
                    n_tests++;
                    if (o_OP_PHASE !== 10'd512) begin
                        n_fail++; $display("FAIL ramp_half got %0h want 200", o_OP_PHASE);
                    end
                end
                if (cnt == 128) begin
                    n_tests++;
                    if (o_OP_PHASE !== 10'd0) begin
                        n_fail++; $display("FAIL ramp_wrap got %0h want 0", o_OP_PHASE);
                    end
                end
            end
        end
        n_tests++;
        if (cnt != 128) begin n_fail++; $display("FAIL ramp_frames got %0d want 128", cnt); end
        set_slot(0, 9'd0, 3'd0, 4'd0, 1'b0, 3'd0, 19'd0);
    endtask

    task automatic test_mul_pm();
        logic [18:0] data;
        logic        err, got;
        int          lat;
        int          slots [7] = '{1, 2, 3, 4, 6, 7, 8};
        set_slot(1, 9'd256, 3'd4, 4'h0, 1'b0, 3'd0, 19'd2048);
        set_slot(2, 9'd256, 3'd4, 4'hA, 1'b0, 3'd0, 19'd40960);
        set_slot(3, 9'd256, 3'd4, 4'hB, 1'b0, 3'd0, 19'd40960);
        set_slot(4, 9'd256, 3'd4, 4'hE, 1'b0, 3'd0, 19'd61440);
        set_slot(6, 9'h1C0, 3'd1, 4'd1, 1'b1, 3'b110, 19'h379);
        set_slot(7, 9'h1C0, 3'd1, 4'd1, 1'b1, 3'b001, 19'h383);
        set_slot(8, 9'h1C0, 3'd1, 4'd1, 1'b0, 3'b110, 19'h380);
        for (int i = 0; i < 3 * SLOTS + 3; i++) begin
            step();
            if (last_valid && last_real && last_slot >= 1 && last_slot <= 8) begin
                n_tests++;
                if (o_OP_PHASE !== model_phase[last_slot][18:9]) begin
                    n_fail++;
                    $display("FAIL mulpm_phase slot %0d got %0h want %0h", last_slot, o_OP_PHASE,
                             model_phase[last_slot][18:9]);
                end
            end
        end
        foreach (slots[k]) begin
            do_read(slots[k], data, err, lat, got);
            n_tests++;
            if (!got || err !== 1'b0 || data !== model_phase[slots[k]]) begin
                n_fail++;
                $display("FAIL mulpm_read slot %0d got %0h err %b ack %b want %0h", slots[k],
                         data, err, got, model_phase[slots[k]]);
            end
        end
    endtask

    task automatic test_keyon_freeze();
        logic [18:0] data;
        logic        err, got, seen;
        int          lat, frames;
        set_slot(5, 9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 19'd4096);
        repeat (2 * SLOTS + 3) step();
        prst_once[5] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * SLOTS && !seen; i++) begin
            step();
            if (last_real && last_slot == 5 && last_prst) seen = 1'b1;
        end
        n_tests++;
        if (!seen || o_OP_PHASE !== 10'd8) begin
            n_fail++; $display("FAIL keyon_phase got %0h seen %b want 8", o_OP_PHASE, seen);
        end
        frz_t[5] = 1'b1;
        frames = 0;
        for (int i = 0; i < 4 * SLOTS && frames < 3; i++) begin
            step();
            if (last_real && last_slot == 5) begin
                frames++;
                n_tests++;
                if (o_OP_PHASE !== 10'd8) begin
                    n_fail++; $display("FAIL freeze_phase frame %0d got %0h want 8", frames, o_OP_PHASE);
                end
            end
        end
        do_read(5, data, err, lat, got);
        n_tests++;
        if (!got || data !== 19'd4096) begin
            n_fail++; $display("FAIL freeze_read got %0h ack %b want 1000", data, got);
        end
        frz_t[5] = 1'b0;
    endtask

    task automatic test_readback();
        logic [18:0] data;
        logic        err, got, seen;
        int          lat;
        set_slot(17, 9'd100, 3'd2, 4'd3, 1'b0, 3'd0, 19'd1200);
        repeat (SLOTS + 3) step();
        wait_write(17, seen);
        do_read(17, data, err, lat, got);
        n_tests += 2;
        if (!seen || !got || lat != 19) begin
            n_fail++; $display("FAIL read17_latency got %0d ack %b want 19", lat, got);
        end
        if (data !== model_phase[17] || err !== 1'b0) begin
            n_fail++; $display("FAIL read17_data got %0h err %b want %0h", data, err, model_phase[17]);
        end
    endtask

    task automatic test_rd_err_gating();
        logic [9:0] exp_op;
        rd_req = 1'b1; rd_slot = 5'd20;
        step();
        n_tests++;
        if (o_RD_ACK !== 1'b0) begin n_fail++; $display("FAIL err_ack_early got %b want 0", o_RD_ACK); end
        step();
        rd_req = 1'b0;
        n_tests += 3;
        if (o_RD_ACK !== 1'b1) begin n_fail++; $display("FAIL err_ack got %b want 1", o_RD_ACK); end
        if (o_RD_ERR !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b want 1", o_RD_ERR); end
        if (o_RD_DATA !== 19'd0) begin n_fail++; $display("FAIL err_data got %0h want 0", o_RD_DATA); end
        exp_op = model_phase[last_slot][18:9];
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            n_tests += 2;
            if (o_RD_ACK !== 1'b1) begin n_fail++; $display("FAIL gated_ack got %b want 1", o_RD_ACK); end
            if (o_OP_PHASE !== exp_op) begin
                n_fail++; $display("FAIL gated_phase got %0h want %0h", o_OP_PHASE, exp_op);
            end
        end
        step();
        n_tests++;
        if (o_RD_ACK !== 1'b0) begin n_fail++; $display("FAIL ack_pulse got %b want 0", o_RD_ACK); end
    endtask

    task automatic test_reset_mid_read();
        logic [18:0] data;
        logic        err, got, seen;
        int          lat, acks;
        set_slot(9, 9'd256, 3'd4, 4'd1, 1'b0, 3'd0, 19'd4096);
        repeat (SLOTS + 3) step();
        wait_write(9, seen);
        rd_req = 1'b1; rd_slot = 5'd9;
        repeat (4) step();
        rst = 1'b1; rd_req = 1'b0;
        @(posedge clk);
        #1;
        n_tests += 6;
        if (o_OP_PHASE !== 10'd0) begin n_fail++; $display("FAIL midrst_op_phase got %0h want 0", o_OP_PHASE); end
        if (o_OP_SLOT !== 5'd0) begin n_fail++; $display("FAIL midrst_op_slot got %0d want 0", o_OP_SLOT); end
        if (o_OP_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", o_OP_VALID); end
        if (o_RD_ACK !== 1'b0) begin n_fail++; $display("FAIL midrst_ack got %b want 0", o_RD_ACK); end
        if (o_RD_DATA !== 19'd0) begin n_fail++; $display("FAIL midrst_data got %0h want 0", o_RD_DATA); end
        if (o_RD_ERR !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", o_RD_ERR); end
        rst = 1'b0;
        clear_tables();
        init_model();
        acks = 0;
        for (int i = 0; i < 2 * SLOTS + 4; i++) begin
            step();
            if (o_RD_ACK !== 1'b0) acks++;
        end
        n_tests++;
        if (acks != 0) begin n_fail++; $display("FAIL midrst_stray_ack got %0d want 0", acks); end
        do_read(9, data, err, lat, got);
        n_tests++;
        if (!got || data !== 19'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_phase_clear got %0h ack %b err %b want 0", data, got, err);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ncen = 1'b1; sync = 1'b0; fnum = '0; blk = '0; mul = '0; pm = 1'b0;
        pmval = '0; phase_rst = 1'b0; freeze = 1'b0; rd_req = 1'b0; rd_slot = '0;
        clear_tables();
        init_model();
        test_reset();
        test_ramp();
        test_mul_pm();
        test_keyon_freeze();
        test_readback();
        test_rd_err_gating();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
